// File: rtl/gate_test_pkg.sv
// Shared types and sizes for the AND-gate test sequencer.
package gate_test_pkg;
   localparam int NUM_VEC = 8;
   localparam int VEC_W   = 3;
   localparam int ERR_W   = 4;
   localparam int TMR_W   = 4;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRIVE  = 3'd1,
      ST_SETTLE = 3'd2,
      ST_CHECK  = 3'd3,
      ST_DONE   = 3'd4
   } state_e;
endpackage

// File: rtl/gate_test_seq_settle_timer.sv
// Settle timer: cleared on load, counts 0..SETTLE_CYC-1 while enabled,
// flags expire on the last count and wraps back to 0.
module settle_timer
   import gate_test_pkg::*;
#(
   parameter int SETTLE_CYC = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic en,
   output logic expire
);
   localparam logic [TMR_W-1:0] LAST = (SETTLE_CYC == 0) ? '0 : TMR_W'(SETTLE_CYC - 1);

   logic [TMR_W-1:0] cnt_q, cnt_d;

   assign expire = en && (cnt_q == LAST);

   // next count: load clears, enabled counting wraps on expire
   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = '0;
      else if (en)
         cnt_d = expire ? '0 : cnt_q + TMR_W'(1);
   end

   // counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end
endmodule

// File: rtl/gate_test_seq.sv
// Sequencer that walks all 8 input vectors through a 3-input AND gate,
// waits for the gate to settle, and compares both the a&b node and the
// final output against their ideal values.
module gate_test_seq
   import gate_test_pkg::*;
#(
   parameter int SETTLE_CYC = 2,
   parameter int NUM_VEC    = gate_test_pkg::NUM_VEC
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   output logic             dut_a,
   output logic             dut_b,
   output logic             dut_c,
   input  logic             dut_d,
   input  logic             dut_e,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic [7:0]       fail_vec
);
   state_e             state_q, state_d;
   logic [VEC_W-1:0]   vec_q, vec_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic [7:0]         fail_q, fail_d;
   logic               pass_q, pass_d;
   logic               tmr_load, tmr_en, tmr_expire;
   logic               drv_en, exp_d, exp_e, mism;

   settle_timer #(.SETTLE_CYC(SETTLE_CYC)) u_tmr (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (tmr_load),
      .en     (tmr_en),
      .expire (tmr_expire)
   );

   // gate stimulus is only driven while a vector is in flight
   assign drv_en = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_CHECK);
   assign dut_a  = drv_en & vec_q[2];
   assign dut_b  = drv_en & vec_q[1];
   assign dut_c  = drv_en & vec_q[0];

   // ideal gate response for the current vector
   assign exp_d = vec_q[2] & vec_q[1];
   assign exp_e = vec_q[2] & vec_q[1] & vec_q[0];
   assign mism  = (dut_d != exp_d) || (dut_e != exp_e);

   assign busy     = (state_q != ST_IDLE);
   assign done     = (state_q == ST_DONE) && !abort;
   assign pass     = pass_q;
   assign err_cnt  = err_q;
   assign fail_vec = fail_q;

   // next-state and result bookkeeping; abort overrides everything outside IDLE
   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      err_d    = err_q;
      fail_d   = fail_q;
      pass_d   = pass_q;
      tmr_load = 1'b0;
      tmr_en   = 1'b0;
      if (abort && state_q != ST_IDLE) begin
         state_d  = ST_IDLE;
         pass_d   = 1'b0;
         tmr_load = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start && !abort) begin
                  state_d = ST_DRIVE;
                  vec_d   = '0;
                  err_d   = '0;
                  fail_d  = '0;
                  pass_d  = 1'b0;
               end
            end
            ST_DRIVE: begin
               tmr_load = 1'b1;
               state_d  = (SETTLE_CYC > 0) ? ST_SETTLE : ST_CHECK;
            end
            ST_SETTLE: begin
               tmr_en = 1'b1;
               if (tmr_expire) state_d = ST_CHECK;
            end
            ST_CHECK: begin
               if (mism) begin
                  fail_d[vec_q] = 1'b1;
                  if (err_q < ERR_W'(NUM_VEC)) err_d = err_q + ERR_W'(1);
               end
               if (vec_q == VEC_W'(NUM_VEC - 1)) begin
                  state_d = ST_DONE;
                  // pass is visible alongside the done pulse
                  pass_d  = (err_d == '0);
               end else begin
                  vec_d   = vec_q + VEC_W'(1);
                  state_d = ST_DRIVE;
               end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // state and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         vec_q   <= '0;
         err_q   <= '0;
         fail_q  <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         err_q   <= err_d;
         fail_q  <= fail_d;
         pass_q  <= pass_d;
      end
   end
endmodule

// File: tb/tb_gate_test_seq.sv
// Bench for gate_test_seq: a timeline model (position within the run)
// checked every cycle, plus directed literal checks of key results.
module tb_gate_test_seq;
   localparam int S = 2;
   localparam int P = S + 2;
   localparam int L = 8 * P;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0, abort = 1'b0, start0 = 1'b0;
   logic dut_a, dut_b, dut_c, dut_d, dut_e, busy, done, pass;
   logic [3:0] err_cnt;
   logic [7:0] fail_vec;
   logic a0, b0, c0, d0, e0, busy0, done0, pass0;
   logic [3:0] err0;
   logic [7:0] fail0;
   int fault = 0;   // 0 good, 1 e stuck-at-1, 2 d stuck-at-0
   int nvec = 0, nerr = 0;

   always #5 clk = ~clk;

   gate_test_seq #(.SETTLE_CYC(S)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
      .dut_a(dut_a), .dut_b(dut_b), .dut_c(dut_c), .dut_d(dut_d), .dut_e(dut_e),
      .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .fail_vec(fail_vec));

   gate_test_seq #(.SETTLE_CYC(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort),
      .dut_a(a0), .dut_b(b0), .dut_c(c0), .dut_d(d0), .dut_e(e0),
      .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .fail_vec(fail0));

   // gate under test, optionally faulty
   assign dut_d = (fault == 2) ? 1'b0 : (dut_a & dut_b);
   assign dut_e = (fault == 1) ? 1'b1 : (dut_a & dut_b & dut_c);
   assign d0    = a0 & b0;
   assign e0    = a0 & b0 & c0;

   // ideal AND outputs: node high for vectors 6,7; output high only for 7
   function automatic bit bad(input int v);
      bit gd, ge;
      gd = (fault == 2) ? 1'b0 : (v >= 6);
      ge = (fault == 1) ? 1'b1 : (v == 7);
      return (gd != (v >= 6)) || (ge != (v == 7));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // model: run position m_k counts cycles since the accepting edge
   bit        m_act = 0;
   int        m_k = 0, m_err = 0;
   bit [7:0]  m_fail = 0;
   bit        m_pass = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_act <= 0; m_k <= 0; m_err <= 0; m_fail <= 0; m_pass <= 0;
      end else if (m_act && abort) begin
         m_act <= 0; m_pass <= 0;
      end else if (!m_act) begin
         if (start && !abort) begin
            m_act <= 1; m_k <= 0; m_err <= 0; m_fail <= 0; m_pass <= 0;
         end
      end else if (m_k == L) begin
         m_act <= 0;
      end else begin
         m_k <= m_k + 1;
         if (m_k % P == P - 1) begin
            if (bad(m_k / P)) begin
               m_err <= m_err + 1;
               m_fail[m_k / P] <= 1'b1;
            end
            if (m_k == L - 1) m_pass <= ((m_err + (bad(m_k / P) ? 1 : 0)) == 0);
         end
      end
   end

   // per-cycle compare against the model
   always @(negedge clk) begin
      logic [2:0] ev;
      ev = (m_act && m_k < L) ? 3'(m_k / P) : 3'd0;
      chk("abc",      {29'd0, dut_a, dut_b, dut_c}, {29'd0, ev});
      chk("busy",     {31'd0, busy},  {31'd0, m_act});
      chk("done",     {31'd0, done},  {31'd0, (m_act && m_k == L)});
      chk("pass",     {31'd0, pass},  {31'd0, m_pass});
      chk("err_cnt",  {28'd0, err_cnt}, 32'(m_err));
      chk("fail_vec", {24'd0, fail_vec}, {24'd0, m_fail});
   end

   task automatic step();
      @(negedge clk); #2;
   endtask

   // pulse start, then count cycles until done (cycle 0 = DRIVE of vector 0)
   task automatic run(output int cyc);
      start = 1'b1; step(); start = 1'b0;
      cyc = 0;
      while (!done && cyc < 200) begin step(); cyc++; end
      if (cyc >= 200) chk("run_timeout", 32'(cyc), 32'd0);
   endtask

   initial begin
      int cyc;
      step(); step();
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_abc",  {29'd0, dut_a, dut_b, dut_c}, 32'd0);
      chk("rst_err",  {28'd0, err_cnt}, 32'd0);
      rst_n = 1'b1; step();

      // good gate
      run(cyc);
      chk("good_len",  32'(cyc), 32'd32);
      chk("good_pass", {31'd0, pass}, 32'd1);
      chk("good_err",  {28'd0, err_cnt}, 32'd0);
      chk("good_fail", {24'd0, fail_vec}, 32'h00);
      step(); step();

      // output stuck-at-1
      fault = 1;
      run(cyc);
      chk("e1_pass", {31'd0, pass}, 32'd0);
      chk("e1_err",  {28'd0, err_cnt}, 32'd7);
      chk("e1_fail", {24'd0, fail_vec}, 32'h7F);
      step();

      // node stuck-at-0; results hold after DONE
      fault = 2;
      run(cyc);
      chk("d0_err",  {28'd0, err_cnt}, 32'd2);
      chk("d0_fail", {24'd0, fail_vec}, 32'hC0);
      step(); step(); step();
      chk("d0_hold", {28'd0, err_cnt}, 32'd2);
      fault = 0;

      // zero-settle build
      start0 = 1'b1; step(); start0 = 1'b0;
      cyc = 0;
      while (!done0 && cyc < 200) begin step(); cyc++; end
      chk("s0_len",  32'(cyc), 32'd16);
      chk("s0_pass", {31'd0, pass0}, 32'd1);
      chk("s0_err",  {28'd0, err0}, 32'd0);
      chk("s0_fail", {24'd0, fail0}, 32'h00);
      step();
      chk("s0_idle", {31'd0, busy0}, 32'd0);

      // abort in CHECK of vector 3 (run position 15)
      start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 15; i++) step();
      chk("ab_vec", {29'd0, dut_a, dut_b, dut_c}, 32'd3);
      abort = 1'b1; step(); abort = 1'b0;
      chk("ab_busy", {31'd0, busy}, 32'd0);
      chk("ab_abc",  {29'd0, dut_a, dut_b, dut_c}, 32'd0);
      chk("ab_pass", {31'd0, pass}, 32'd0);
      step(); step();
      run(cyc);
      chk("ab_rerun", {31'd0, pass}, 32'd1);
      step();

      // abort beats start in IDLE
      start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
      chk("ab_start", {31'd0, busy}, 32'd0);

      // reset during SETTLE of vector 5 (run position 21)
      start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 21; i++) step();
      rst_n = 1'b0; #1;
      chk("mr_busy", {31'd0, busy}, 32'd0);
      chk("mr_abc",  {29'd0, dut_a, dut_b, dut_c}, 32'd0);
      chk("mr_err",  {28'd0, err_cnt}, 32'd0);
      step(); rst_n = 1'b1; step();

      // start held during busy does not alter timing
      start = 1'b1; step();
      cyc = 0;
      while (!done && cyc < 200) begin
         if (cyc == 10) start = 1'b0;
         step(); cyc++;
      end
      chk("held_len",  32'(cyc), 32'd32);
      chk("held_pass", {31'd0, pass}, 32'd1);
      step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
